// File: rtl/spart_word_assembler.sv
// spart_word_assembler
//   Frames the SPART receive byte stream (optional sync byte, little-endian
//   payload bytes, optional XOR checksum byte) into WORD_WIDTH-bit words.
//   Completed words are queued in a DEPTH-entry show-ahead FIFO.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   rx_valid/data - one-cycle byte strobe from the receive path
//   word_data     - FIFO head word, valid while word_valid is high
//   word_valid    - FIFO not empty
//   word_ready    - consumer pop (taken when word_valid && word_ready)
//   fifo_count    - words currently stored
//   chk_err       - pulse: checksum mismatch, frame dropped
//   timeout_err   - pulse: partial frame dropped after idle timeout
//   ovf_err       - pulse: completed word dropped, FIFO full
//   err_count     - saturating count of the three error pulses
module spart_word_assembler #(
  parameter int unsigned WORD_WIDTH     = 13,
  parameter int unsigned DEPTH          = 4,
  parameter bit          SYNC_EN        = 1'b1,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter bit          CHK_EN         = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rx_valid,
  input  logic [7:0]             rx_data,
  output logic [WORD_WIDTH-1:0]  word_data,
  output logic                   word_valid,
  input  logic                   word_ready,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   chk_err,
  output logic                   timeout_err,
  output logic                   ovf_err,
  output logic [7:0]             err_count
);

  localparam int unsigned NB   = (WORD_WIDTH + 7) / 8;
  localparam int unsigned IdxW = (NB > 1) ? $clog2(NB) : 1;
  localparam int unsigned PtrW = $clog2(DEPTH);

  localparam logic [IdxW-1:0] LastIdx = IdxW'(NB - 1);
  localparam logic [PtrW:0]   DepthC  = (PtrW + 1)'(DEPTH);

  typedef enum logic [1:0] {StHunt, StPayload, StCheck} state_e;
  localparam state_e StStart = SYNC_EN ? StHunt : StPayload;

  state_e                state_q, state_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [7:0]            acc_q, acc_d;
  logic [WORD_WIDTH-1:0] sr_q, sr_d;
  logic [31:0]           tmr_q, tmr_d;
  logic                  chk_err_q, chk_err_d;
  logic                  to_err_q, to_err_d;
  logic                  ovf_err_q, ovf_err_d;
  logic [7:0]            err_count_q, err_count_d;

  logic                  push;
  logic [WORD_WIDTH-1:0] push_word;
  logic                  tmr_active;

  // Framing FSM and idle timer
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    acc_d     = acc_q;
    sr_d      = sr_q;
    tmr_d     = '0;
    push      = 1'b0;
    push_word = sr_q;
    chk_err_d = 1'b0;
    to_err_d  = 1'b0;
    // In PAYLOAD with index 0 and no sync byte we are simply idle between frames.
    tmr_active = (state_q == StCheck) ||
                 ((state_q == StPayload) && ((idx_q != '0) || SYNC_EN));

    if (rx_valid) begin
      case (state_q)
        StHunt: begin
          if (rx_data == SYNC_BYTE) begin
            state_d = StPayload;
            idx_d   = '0;
            acc_d   = '0;
          end
        end
        StPayload: begin
          for (int i = 0; i < int'(WORD_WIDTH); i++) begin
            if (idx_q == IdxW'(i / 8)) sr_d[i] = rx_data[3'(i % 8)];
          end
          acc_d = acc_q ^ rx_data;
          if (idx_q == LastIdx) begin
            idx_d = '0;
            if (CHK_EN) begin
              state_d = StCheck;
            end else begin
              push      = 1'b1;
              push_word = sr_d;
              state_d   = StStart;
              acc_d     = '0;
            end
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        StCheck: begin
          if (rx_data == acc_q) push = 1'b1;
          else chk_err_d = 1'b1;
          state_d = StStart;
          idx_d   = '0;
          acc_d   = '0;
        end
        default: state_d = StStart;
      endcase
    end else if (tmr_active) begin
      if ((TIMEOUT_CYCLES != 0) && (tmr_q + 32'd1 == TIMEOUT_CYCLES)) begin
        to_err_d = 1'b1;
        state_d  = StStart;
        idx_d    = '0;
        acc_d    = '0;
      end else begin
        tmr_d = tmr_q + 32'd1;
      end
    end
  end

  // FIFO
  logic [WORD_WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]       wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PtrW:0]         count_q, count_d;
  logic                  pop, full, push_ok;

  always_comb begin
    pop       = (count_q != '0) && word_ready;
    full      = (count_q == DepthC);
    // A simultaneous pop frees the slot, so a full FIFO still accepts the push.
    push_ok   = push && (!full || pop);
    ovf_err_d = push && full && !pop;
    wptr_d    = push_ok ? wptr_q + 1'b1 : wptr_q;
    rptr_d    = pop ? rptr_q + 1'b1 : rptr_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Error counter, saturating at 255
  logic [1:0] n_err;
  logic [8:0] err_sum;
  always_comb begin
    n_err       = 2'(chk_err_d) + 2'(to_err_d) + 2'(ovf_err_d);
    err_sum     = {1'b0, err_count_q} + {7'd0, n_err};
    err_count_d = err_sum[8] ? 8'hFF : err_sum[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StStart;
      idx_q       <= '0;
      acc_q       <= '0;
      sr_q        <= '0;
      tmr_q       <= '0;
      chk_err_q   <= 1'b0;
      to_err_q    <= 1'b0;
      ovf_err_q   <= 1'b0;
      err_count_q <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      sr_q        <= sr_d;
      tmr_q       <= tmr_d;
      chk_err_q   <= chk_err_d;
      to_err_q    <= to_err_d;
      ovf_err_q   <= ovf_err_d;
      err_count_q <= err_count_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= push_word;
  end

  assign word_data   = mem_q[rptr_q];
  assign word_valid  = (count_q != '0);
  assign fifo_count  = count_q;
  assign chk_err     = chk_err_q;
  assign timeout_err = to_err_q;
  assign ovf_err     = ovf_err_q;
  assign err_count   = err_count_q;

endmodule

// File: tb/tb_spart_word_assembler.sv
module tb_spart_word_assembler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Default configuration instance
  logic        rst_a, rx_valid_a, word_ready_a;
  logic [7:0]  rx_data_a;
  logic [12:0] word_data_a;
  logic        word_valid_a, chk_err_a, timeout_err_a, ovf_err_a;
  logic [2:0]  fifo_count_a;
  logic [7:0]  err_count_a;

  spart_word_assembler u_dut_a (
    .clk        (clk),
    .rst        (rst_a),
    .rx_valid   (rx_valid_a),
    .rx_data    (rx_data_a),
    .word_data  (word_data_a),
    .word_valid (word_valid_a),
    .word_ready (word_ready_a),
    .fifo_count (fifo_count_a),
    .chk_err    (chk_err_a),
    .timeout_err(timeout_err_a),
    .ovf_err    (ovf_err_a),
    .err_count  (err_count_a)
  );

  // 32-bit, no sync, no checksum instance
  logic        rst_b, rx_valid_b, word_ready_b;
  logic [7:0]  rx_data_b;
  logic [31:0] word_data_b;
  logic        word_valid_b, chk_err_b, timeout_err_b, ovf_err_b;
  logic [2:0]  fifo_count_b;
  logic [7:0]  err_count_b;

  spart_word_assembler #(
    .WORD_WIDTH(32),
    .SYNC_EN   (1'b0),
    .CHK_EN    (1'b0)
  ) u_dut_b (
    .clk        (clk),
    .rst        (rst_b),
    .rx_valid   (rx_valid_b),
    .rx_data    (rx_data_b),
    .word_data  (word_data_b),
    .word_valid (word_valid_b),
    .word_ready (word_ready_b),
    .fifo_count (fifo_count_b),
    .chk_err    (chk_err_b),
    .timeout_err(timeout_err_b),
    .ovf_err    (ovf_err_b),
    .err_count  (err_count_b)
  );

  // Each byte is held for exactly one clock; returns 1 time unit after that edge.
  task automatic send_a(input logic [7:0] b);
    rx_valid_a = 1'b1;
    rx_data_a  = b;
    @(posedge clk);
    #1;
    rx_valid_a = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] b);
    rx_valid_b = 1'b1;
    rx_data_b  = b;
    @(posedge clk);
    #1;
    rx_valid_b = 1'b0;
  endtask

  task automatic pop_a();
    word_ready_a = 1'b1;
    @(posedge clk);
    #1;
    word_ready_a = 1'b0;
  endtask

  function automatic logic [12:0] ovf_word(input int k);
    return 13'(((16 + k) << 8) + k);
  endfunction

  task automatic test_reset();
    checks++; if (word_valid_a !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", word_valid_a); end
    checks++; if (fifo_count_a !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", fifo_count_a); end
    checks++; if ({chk_err_a, timeout_err_a, ovf_err_a} !== 3'b000) begin errors++; $display("FAIL reset_pulses: got %b want 000", {chk_err_a, timeout_err_a, ovf_err_a}); end
    checks++; if (err_count_a !== 8'd0) begin errors++; $display("FAIL reset_errcnt: got %0d want 0", err_count_a); end
    checks++; if (word_valid_b !== 1'b0) begin errors++; $display("FAIL reset_valid_b: got %b want 0", word_valid_b); end
  endtask

  task automatic test_basic();
    send_a(8'hA5); send_a(8'h34); send_a(8'h12); send_a(8'h26);
    checks++; if (word_valid_a !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b want 1", word_valid_a); end
    checks++; if (word_data_a !== 13'h1234) begin errors++; $display("FAIL basic_data: got %h want 1234", word_data_a); end
    checks++; if (chk_err_a !== 1'b0) begin errors++; $display("FAIL basic_chk: got %b want 0", chk_err_a); end
    checks++; if (fifo_count_a !== 3'd1) begin errors++; $display("FAIL basic_count: got %0d want 1", fifo_count_a); end
    pop_a();
    checks++; if (word_valid_a !== 1'b0) begin errors++; $display("FAIL basic_popped: got %b want 0", word_valid_a); end
  endtask

  task automatic test_checksum();
    send_a(8'hA5); send_a(8'h34); send_a(8'h12); send_a(8'h00);
    checks++; if (chk_err_a !== 1'b1) begin errors++; $display("FAIL chk_pulse: got %b want 1", chk_err_a); end
    checks++; if (err_count_a !== 8'd1) begin errors++; $display("FAIL chk_errcnt: got %0d want 1", err_count_a); end
    checks++; if (word_valid_a !== 1'b0) begin errors++; $display("FAIL chk_dropped: got %b want 0", word_valid_a); end
    @(posedge clk); #1;
    checks++; if (chk_err_a !== 1'b0) begin errors++; $display("FAIL chk_once: got %b want 0", chk_err_a); end
    send_a(8'hA5); send_a(8'hAB); send_a(8'h0C); send_a(8'hA7);
    checks++; if (word_data_a !== 13'h0CAB || word_valid_a !== 1'b1) begin errors++; $display("FAIL chk_recover: got %h/%b want 0cab/1", word_data_a, word_valid_a); end
    pop_a();
  endtask

  task automatic test_framing();
    send_a(8'h00); send_a(8'hFF); send_a(8'hA5); send_a(8'h01); send_a(8'h00); send_a(8'h01);
    checks++; if (fifo_count_a !== 3'd1 || word_data_a !== 13'h0001) begin errors++; $display("FAIL hunt: got cnt %0d data %h want 1/0001", fifo_count_a, word_data_a); end
    pop_a();
    // Upper bits of the last byte fall outside the 13-bit word
    send_a(8'hA5); send_a(8'hFF); send_a(8'hFF); send_a(8'h00);
    checks++; if (word_data_a !== 13'h1FFF) begin errors++; $display("FAIL trunc: got %h want 1fff", word_data_a); end
    pop_a();
    // Sync value inside a frame is data
    send_a(8'hA5); send_a(8'hA5); send_a(8'h00); send_a(8'hA5);
    checks++; if (word_data_a !== 13'h00A5 || word_valid_a !== 1'b1) begin errors++; $display("FAIL sync_as_data: got %h/%b want 00a5/1", word_data_a, word_valid_a); end
    pop_a();
  endtask

  task automatic test_push_pop_empty();
    word_ready_a = 1'b1;
    send_a(8'hA5); send_a(8'h02); send_a(8'h00); send_a(8'h02);
    checks++; if (fifo_count_a !== 3'd1 || word_data_a !== 13'h0002) begin errors++; $display("FAIL pp_empty: got cnt %0d data %h want 1/0002", fifo_count_a, word_data_a); end
    @(posedge clk); #1;
    word_ready_a = 1'b0;
    checks++; if (word_valid_a !== 1'b0) begin errors++; $display("FAIL pp_empty_pop: got %b want 0", word_valid_a); end
  endtask

  task automatic test_timeout();
    int first = 0;
    int pulses = 0;
    send_a(8'hA5); send_a(8'h34);
    for (int n = 1; n <= 50010; n++) begin
      @(posedge clk); #1;
      if (timeout_err_a === 1'b1) begin
        pulses++;
        if (first == 0) first = n;
      end
    end
    checks++; if (first != 50000) begin errors++; $display("FAIL to_cycle: got %0d want 50000", first); end
    checks++; if (pulses != 1) begin errors++; $display("FAIL to_pulses: got %0d want 1", pulses); end
    checks++; if (err_count_a !== 8'd2) begin errors++; $display("FAIL to_errcnt: got %0d want 2", err_count_a); end
    send_a(8'hA5); send_a(8'h78); send_a(8'h56); send_a(8'h2E);
    checks++; if (word_data_a !== 13'h1678 || fifo_count_a !== 3'd1) begin errors++; $display("FAIL to_recover: got %h cnt %0d want 1678/1", word_data_a, fifo_count_a); end
    pop_a();
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 5; i++) begin
      send_a(8'hA5); send_a(8'(i)); send_a(8'(16 + i)); send_a(8'h10);
      checks++; if (fifo_count_a !== 3'((i < 4) ? i : 4)) begin errors++; $display("FAIL ovf_count%0d: got %0d want %0d", i, fifo_count_a, (i < 4) ? i : 4); end
      checks++; if (ovf_err_a !== (i == 5)) begin errors++; $display("FAIL ovf_pulse%0d: got %b want %b", i, ovf_err_a, i == 5); end
    end
    checks++; if (err_count_a !== 8'd3) begin errors++; $display("FAIL ovf_errcnt: got %0d want 3", err_count_a); end
    word_ready_a = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      checks++; if (word_data_a !== ovf_word(k)) begin errors++; $display("FAIL ovf_order%0d: got %h want %h", k, word_data_a, ovf_word(k)); end
      @(posedge clk); #1;
    end
    word_ready_a = 1'b0;
    checks++; if (word_valid_a !== 1'b0) begin errors++; $display("FAIL ovf_drained: got %b want 0", word_valid_a); end
  endtask

  task automatic test_back_to_back();
    int exp_k[4] = '{2, 3, 4, 6};
    for (int i = 1; i <= 4; i++) begin
      send_a(8'hA5); send_a(8'(i)); send_a(8'(16 + i)); send_a(8'h10);
    end
    send_a(8'hA5); send_a(8'h06); send_a(8'h16);
    word_ready_a = 1'b1;
    send_a(8'h10);
    word_ready_a = 1'b0;
    checks++; if (fifo_count_a !== 3'd4) begin errors++; $display("FAIL full_pp_count: got %0d want 4", fifo_count_a); end
    checks++; if (ovf_err_a !== 1'b0) begin errors++; $display("FAIL full_pp_ovf: got %b want 0", ovf_err_a); end
    checks++; if (err_count_a !== 8'd3) begin errors++; $display("FAIL full_pp_errcnt: got %0d want 3", err_count_a); end
    word_ready_a = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checks++; if (word_data_a !== ovf_word(exp_k[k])) begin errors++; $display("FAIL full_pp_order%0d: got %h want %h", k, word_data_a, ovf_word(exp_k[k])); end
      @(posedge clk); #1;
    end
    word_ready_a = 1'b0;
  endtask

  task automatic test_wide();
    send_b(8'h78); send_b(8'h56); send_b(8'h34); send_b(8'h12);
    checks++; if (word_valid_b !== 1'b1 || word_data_b !== 32'h12345678) begin errors++; $display("FAIL wide_data: got %h/%b want 12345678/1", word_data_b, word_valid_b); end
    word_ready_b = 1'b1; @(posedge clk); #1; word_ready_b = 1'b0;
    send_b(8'hAA); send_b(8'hBB);
    rst_b = 1'b1; @(posedge clk); #1; rst_b = 1'b0;
    checks++; if (fifo_count_b !== 3'd0) begin errors++; $display("FAIL wide_rst_count: got %0d want 0", fifo_count_b); end
    send_b(8'h11); send_b(8'h22); send_b(8'h33); send_b(8'h44);
    checks++; if (fifo_count_b !== 3'd1 || word_data_b !== 32'h44332211) begin errors++; $display("FAIL wide_after_rst: got cnt %0d data %h want 1/44332211", fifo_count_b, word_data_b); end
  endtask

  initial begin
    rst_a = 1'b1; rx_valid_a = 1'b0; rx_data_a = '0; word_ready_a = 1'b0;
    rst_b = 1'b1; rx_valid_b = 1'b0; rx_data_b = '0; word_ready_b = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_a = 1'b0;
    rst_b = 1'b0;
    test_reset();
    test_basic();
    test_checksum();
    test_framing();
    test_push_pop_empty();
    test_timeout();
    test_overflow();
    test_back_to_back();
    test_wide();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
